// File: rtl/decimator_v2.sv
// Decimator: 4-tap boxcar FIR (taps 1/4) with round-half-up, saturation to OUT_WIDTH,
// and one registered output per DEC_FACTOR accepted input samples.
module decimator_v2 #(
   parameter int IN_WIDTH   = 18,
   parameter int OUT_WIDTH  = 15,
   parameter int DEC_FACTOR = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  xin,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out,
   output logic                        ovf
);

   localparam int SUM_W = IN_WIDTH + 2;
   localparam int CNT_W = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
   localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [SUM_W-1:0] OUT_MIN = -OUT_MAX - SUM_W'(1);
   localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DEC_FACTOR - 1);

   // Delay line packed as {d2, d1, d0}; d0 occupies the low slice.
   logic [3*IN_WIDTH-1:0]   dly_reg;
   logic [4*IN_WIDTH-1:0]   taps;
   logic signed [SUM_W-1:0] ext [4];
   logic signed [SUM_W-1:0] sum;
   logic signed [SUM_W-1:0] rnd;
   logic signed [OUT_WIDTH-1:0] y_next;
   logic                    sat_next;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    last_phase;

   assign taps = {dly_reg, xin};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_ext
         assign ext[gi] = {{2{taps[gi*IN_WIDTH + IN_WIDTH - 1]}}, taps[gi*IN_WIDTH +: IN_WIDTH]};
      end
   endgenerate

   assign sum = ext[0] + ext[1] + ext[2] + ext[3];
   // Adding 2 before the arithmetic shift rounds ties toward +inf.
   assign rnd = (sum + SUM_W'(2)) >>> 2;

   always_comb begin
      y_next   = rnd[OUT_WIDTH-1:0];
      sat_next = 1'b0;
      if (rnd > OUT_MAX) begin
         y_next   = OUT_MAX[OUT_WIDTH-1:0];
         sat_next = 1'b1;
      end else if (rnd < OUT_MIN) begin
         y_next   = OUT_MIN[OUT_WIDTH-1:0];
         sat_next = 1'b1;
      end
   end

   assign last_phase = (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_reg   <= '0;
         cnt_reg   <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         if (in_valid) begin
            dly_reg <= {dly_reg[2*IN_WIDTH-1:0], xin};
            if (last_phase) begin
               cnt_reg   <= '0;
               out       <= y_next;
               ovf       <= sat_next;
               out_valid <= 1'b1;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_decimator_v2.sv
// Bench for decimator_v2: DEC_FACTOR=2 and DEC_FACTOR=1 instances share stimulus and are
// compared every cycle against a sample-history reference model.
module tb_decimator_v2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic signed [17:0] xin;

   logic ov2, ovf2, ov1, ovf1;
   logic signed [14:0] out2, out1;

   int tests_run = 0;
   int tests_failed = 0;

   int hist [2][$];
   int df [2] = '{2, 1};
   int e_out [2];
   int e_val [2];
   int e_ovf [2];

   always #5 clk = ~clk;

   decimator_v2 #(.IN_WIDTH(18), .OUT_WIDTH(15), .DEC_FACTOR(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .xin(xin),
      .out_valid(ov2), .out(out2), .ovf(ovf2)
   );

   decimator_v2 #(.IN_WIDTH(18), .OUT_WIDTH(15), .DEC_FACTOR(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .xin(xin),
      .out_valid(ov1), .out(out1), .ovf(ovf1)
   );

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Mean of four samples, rounded half toward +inf, clamped to the 15-bit range.
   function automatic void calc(input int a, input int b, input int c, input int d,
                                output int y, output int sat);
      int s2, r;
      s2 = a + b + c + d + 2;
      r  = (s2 >= 0) ? (s2 / 4) : -((-s2 + 3) / 4);
      sat = 0;
      y = r;
      if (r > 16383) begin y = 16383; sat = 1; end
      else if (r < -16384) begin y = -16384; sat = 1; end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         hist[i].delete();
         e_out[i] = 0; e_val[i] = 0; e_ovf[i] = 0;
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, " out_valid df2"}, int'(ov2), e_val[0]);
      check({ph, " ovf df2"}, int'(ovf2), e_ovf[0]);
      check({ph, " out df2"}, int'(out2), e_out[0]);
      check({ph, " out_valid df1"}, int'(ov1), e_val[1]);
      check({ph, " ovf df1"}, int'(ovf1), e_ovf[1]);
      check({ph, " out df1"}, int'(out1), e_out[1]);
   endtask

   // One clock of stimulus; outputs are checked 1 ns after the edge.
   task automatic step(input bit v, input int x, input string ph, input bit verbose);
      int n, y, sat;
      int t [4];
      in_valid = v;
      xin = x[17:0];
      for (int i = 0; i < 2; i++) begin
         e_val[i] = 0;
         e_ovf[i] = 0;
         if (v) begin
            hist[i].push_back(x);
            n = hist[i].size();
            for (int k = 0; k < 4; k++) t[k] = (n > k) ? hist[i][n-1-k] : 0;
            if (n % df[i] == 0) begin
               calc(t[0], t[1], t[2], t[3], y, sat);
               e_out[i] = y; e_val[i] = 1; e_ovf[i] = sat;
            end
         end
      end
      @(posedge clk);
      #1;
      if (verbose)
         $display("[TB] %s v=%0d x=%0d -> df2 ov=%0d out=%0d ovf=%0d | df1 ov=%0d out=%0d ovf=%0d",
                  ph, v, x, ov2, out2, ovf2, ov1, out1, ovf1);
      check_all(ph);
   endtask

   task automatic sync_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
   endtask

   // Called 1 ns after an edge: reset pulse well clear of both edges.
   task automatic async_pulse(input string ph);
      #1 rst = 1'b1;
      model_reset();
      #1;
      check_all({ph, " async"});
      #1 rst = 1'b0;
   endtask

   int cnt;
   int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
   int rv, rx;

   initial begin
      rst = 1'b1;
      in_valid = 1'b1;
      xin = 18'sd500;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check_all("reset_hold");
      end
      rst = 1'b0;

      // DC 100
      for (int c = 1; c <= 8; c++) begin
         step(1'b1, 100, "dc100", 1'b1);
         if (c == 1) check("dc first-sample no pulse", int'(ov2), 0);
         if (c == 2) check("dc ramp-in out", int'(out2), 50);
         if (c == 4) check("dc settled out", int'(out2), 100);
      end

      // Positive and negative saturation
      sync_reset();
      for (int c = 1; c <= 5; c++) step(1'b1, 131071, "sat_pos", 1'b1);
      check("sat_pos held out", int'(out2), 16383);
      sync_reset();
      for (int c = 1; c <= 4; c++) step(1'b1, -131072, "sat_neg", 1'b1);
      check("sat_neg out", int'(out2), -16384);
      check("sat_neg ovf", int'(ovf2), 1);

      // Rounding at DEC_FACTOR=1
      sync_reset();
      step(1'b1, 1, "rnd_a", 1'b1); check("rnd s=1", int'(out1), 0);
      step(1'b1, 0, "rnd_a", 1'b1); check("rnd s=1b", int'(out1), 0);
      step(1'b1, 1, "rnd_a", 1'b1); check("rnd s=2", int'(out1), 1);
      step(1'b1, 0, "rnd_a", 1'b1); check("rnd s=2b", int'(out1), 1);
      sync_reset();
      step(1'b1, -3, "rnd_b", 1'b1); check("rnd s=-3", int'(out1), -1);
      step(1'b1, -3, "rnd_b", 1'b1); check("rnd s=-6", int'(out1), -1);
      sync_reset();
      step(1'b1, -2, "rnd_c", 1'b1); check("rnd s=-2", int'(out1), 0);
      check("rnd s=-2 valid", int'(ov1), 1);

      // Gapped input
      sync_reset();
      cnt = 0;
      for (int c = 0; c < 7; c++) begin
         step(pat[c] != 0, 40, "gap", 1'b1);
         if (pat[c] != 0) cnt++;
         if (pat[c] != 0 && cnt == 2) check("gap 2nd sample out", int'(out2), 20);
         if (pat[c] != 0 && cnt == 4) check("gap 4th sample out", int'(out2), 40);
      end

      // Asynchronous reset while a pulse is showing, then restart
      sync_reset();
      step(1'b1, 100, "mid", 1'b1);
      step(1'b1, 100, "mid", 1'b1);
      step(1'b1, 100, "mid", 1'b1);
      step(1'b1, 100, "mid", 1'b1);
      async_pulse("mid");
      check("mid async out_valid", int'(ov2), 0);
      check("mid async out", int'(out2), 0);
      step(1'b1, 100, "mid_restart", 1'b1);
      check("restart no early pulse", int'(ov2), 0);
      step(1'b1, 100, "mid_restart", 1'b1);
      check("restart ramp-in", int'(out2), 50);

      // Randomized traffic with occasional asynchronous resets
      sync_reset();
      for (int c = 0; c < 3000; c++) begin
         rv = ($urandom_range(0, 9) < 7) ? 1 : 0;
         case ($urandom_range(0, 5))
            0: rx = 131071;
            1: rx = -131072;
            2: rx = $urandom_range(0, 20) - 10;
            default: rx = int'($urandom_range(0, 262143)) - 131072;
         endcase
         step(rv != 0, rx, "rand", 1'b0);
         if ($urandom_range(0, 199) == 0) async_pulse("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
